// File: rtl/sd_rx_nibble_fifo.sv
// Dual-clock receive FIFO: packs BUS_W-bit SD beats MSB-first into 32-bit words on wclk
// and presents them first-word-fall-through on clk; pointers cross as 2-flop Gray codes.
module sd_rx_nibble_fifo #(
    parameter int BUS_W  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wclk,
    input  logic [BUS_W-1:0]  d,
    input  logic              wr,
    output logic              full,
    output logic              mem_empt,
    output logic [31:0]       q,
    input  logic              rd,
    output logic              empty
);

    localparam int N     = 32 / BUS_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [31:0]       mem [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       pack_reg;
    logic [31:0]       word_next;
    logic [ADDR_W:0]   wbin, wgray, wbin_next;
    logic [ADDR_W:0]   rbin, rgray, rbin_next;
    logic [ADDR_W:0]   rgray_s1, rgray_s2;
    logic [ADDR_W:0]   wgray_s1, wgray_s2;
    logic              accept, commit, pop;

    assign accept    = wr && !full;
    assign commit    = accept && (cnt == CNT_W'(N - 1));
    assign pop       = rd && !empty;
    assign wbin_next = wbin + {{ADDR_W{1'b0}}, 1'b1};
    assign rbin_next = rbin + {{ADDR_W{1'b0}}, 1'b1};

    // Current beat merged into the packing register; on the last beat this is the finished word.
    always_comb begin
        word_next = pack_reg;
        for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k))
                word_next[31-k*BUS_W -: BUS_W] = d;
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            pack_reg <= '0;
            wbin     <= '0;
            wgray    <= '0;
            rgray_s1 <= '0;
            rgray_s2 <= '0;
        end else begin
            if (accept) begin
                pack_reg <= word_next;
                cnt      <= (cnt == CNT_W'(N - 1)) ? '0 : cnt + CNT_W'(1);
            end
            if (commit) begin
                wbin  <= wbin_next;
                wgray <= wbin_next ^ (wbin_next >> 1);
            end
            rgray_s1 <= rgray;
            rgray_s2 <= rgray_s1;
        end
    end

    always_ff @(posedge wclk) begin
        if (commit)
            mem[wbin[ADDR_W-1:0]] <= word_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin     <= '0;
            rgray    <= '0;
            wgray_s1 <= '0;
            wgray_s2 <= '0;
        end else begin
            if (pop) begin
                rbin  <= rbin_next;
                rgray <= rbin_next ^ (rbin_next >> 1);
            end
            wgray_s1 <= wgray;
            wgray_s2 <= wgray_s1;
        end
    end

    // Gray full test: write pointer one lap ahead shows as the top two bits inverted.
    assign full     = (wgray == {~rgray_s2[ADDR_W:ADDR_W-1], rgray_s2[ADDR_W-2:0]});
    assign mem_empt = (wgray == rgray_s2);
    assign empty    = (rgray == wgray_s2);
    assign q        = mem[rbin[ADDR_W-1:0]];

endmodule

// File: tb/tb_sd_rx_nibble_fifo.sv
// Bench for sd_rx_nibble_fifo: directed flag/packing steps, then async random traffic vs a word-queue model.
module tb_sd_rx_nibble_fifo;

    logic        clk, wclk, rst, wr, rd;
    logic [3:0]  d;
    logic        full, mem_empt, empty;
    logic [31:0] q;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    int          n;
    int          rd_cnt;
    int          r_cycles;
    int          w_guard;
    bit          w_timeout;
    bit          rd_now;
    logic [31:0] word;

    sd_rx_nibble_fifo #(.BUS_W(4), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .wclk(wclk), .d(d), .wr(wr),
        .full(full), .mem_empt(mem_empt), .q(q), .rd(rd), .empty(empty)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial begin wclk = 0; forever #20 wclk = ~wclk; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a wclk edge; returns just after the edge that samples the beat.
    task automatic beat(input logic [3:0] v);
        d  = v;
        wr = 1'b1;
        @(posedge wclk); #1;
        wr = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) beat(w[31-4*i -: 4]);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic wait_empty_low();
        n = 0;
        while (empty && n < 3) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; d = '0;
        #2;
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_mem_empt", {31'b0, mem_empt}, 32'd1);
        #10 rst = 1'b0;

        // First word, packing order
        @(posedge wclk); #1;
        for (int i = 1; i <= 8; i++) beat(4'(i));
        check("t1_mem_empt", {31'b0, mem_empt}, 32'd0);
        check("t1_full", {31'b0, full}, 32'd0);
        wait_empty_low();
        check("t1_empty_fall", {31'b0, empty}, 32'd0);
        check("t1_q", q, 32'h12345678);

        // Pop
        pop_one();
        check("t2_empty", {31'b0, empty}, 32'd1);
        n = 0;
        while (!mem_empt && n < 3) begin @(posedge wclk); #1; n++; end
        check("t2_mem_empt", {31'b0, mem_empt}, 32'd1);

        // Fill to full
        @(posedge wclk); #1;
        for (int i = 0; i < 7; i++) send_word(32'hA0000000 | 32'(i));
        for (int b = 0; b < 7; b++) beat(b == 0 ? 4'hA : 4'h0);
        check("t3_full_before", {31'b0, full}, 32'd0);
        beat(4'h7);
        check("t3_full_after", {31'b0, full}, 32'd1);

        // Overflow beats are dropped
        for (int b = 0; b < 8; b++) beat(4'hF);
        check("t4_full_hold", {31'b0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_drain", q, 32'hA0000000 | 32'(i));
            pop_one();
        end
        check("t4_empty", {31'b0, empty}, 32'd1);
        n = 0;
        while (full && n < 3) begin @(posedge wclk); #1; n++; end
        check("t4_full_release", {31'b0, full}, 32'd0);

        // Reset mid-word discards the partial word
        @(posedge wclk); #1;
        for (int b = 0; b < 5; b++) beat(4'h5);
        rst = 1'b1; #3 rst = 1'b0;
        check("t5_rst_empty", {31'b0, empty}, 32'd1);
        check("t5_rst_mem_empt", {31'b0, mem_empt}, 32'd1);
        @(posedge wclk); #1;
        send_word(32'h99999999);
        wait_empty_low();
        check("t5_empty_fall", {31'b0, empty}, 32'd0);
        check("t5_q", q, 32'h99999999);
        pop_one();
        repeat (20) @(posedge clk);
        #1;
        check("t5_only_word", {31'b0, empty}, 32'd1);

        // Random traffic on asynchronous clocks
        rd_cnt = 0;
        w_timeout = 1'b0;
        fork
            begin
                @(posedge wclk); #1;
                for (int w = 0; w < 100 && !w_timeout; w++) begin
                    word = $urandom;
                    for (int b = 0; b < 8 && !w_timeout; b++) begin
                        w_guard = 0;
                        while ((full || $urandom_range(0, 3) == 0) && w_guard < 5000) begin
                            @(posedge wclk); #1; w_guard++;
                        end
                        if (w_guard >= 5000) w_timeout = 1'b1;
                        else beat(word[31-4*b -: 4]);
                    end
                    if (!w_timeout) exp_q.push_back(word);
                end
            end
            begin
                r_cycles = 0;
                while (rd_cnt < 100 && r_cycles < 40000) begin
                    @(negedge clk);
                    r_cycles++;
                    rd_now = ($urandom_range(0, 2) != 0);
                    if (rd_now && !empty) begin
                        check("rand_avail", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            check("rand_word", q, exp_q[0]);
                            void'(exp_q.pop_front());
                        end
                        rd_cnt++;
                    end
                    rd = rd_now;
                    @(posedge clk); #1;
                    rd = 1'b0;
                end
            end
        join
        check("rand_writer_timeout", {31'b0, w_timeout}, 32'd0);
        check("rand_count", 32'(rd_cnt), 32'd100);
        check("rand_leftover", 32'(exp_q.size()), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rand_final_empty", {31'b0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
